// File: rtl/bullet_pkg.sv
// bullet_pkg: shared types and constants for the bullet subsystem.
//   dir_t        2-bit facing code (left/right/down/up)
//   P1/P2 keys   default fire keycodes for each player
//   fire_state_t fire controller states
package bullet_pkg;

  typedef logic [1:0] dir_t;

  localparam dir_t DIR_LEFT  = 2'b00;
  localparam dir_t DIR_RIGHT = 2'b01;
  localparam dir_t DIR_DOWN  = 2'b10;
  localparam dir_t DIR_UP    = 2'b11;

  localparam logic [7:0] P1_FIRE_KEY = 8'd44;
  localparam logic [7:0] P2_FIRE_KEY = 8'd88;

  typedef enum logic {
    READY    = 1'b0,
    COOLDOWN = 1'b1
  } fire_state_t;

endpackage

// File: rtl/bullet_slot_alloc.sv
// bullet_slot_alloc: combinational priority encoder picking the lowest free slot.
//   free     in  N   1 = slot available
//   onehot   out N   one-hot of the lowest set bit of free (0 if none)
//   idx      out IW  index of that bit (0 if none)
//   any_free out 1   at least one slot is free
module bullet_slot_alloc #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  free,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          any_free
);

  // Scan from the top down so the lowest free index is the last one written.
  always_comb begin
    onehot = '0;
    idx    = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (free[i]) begin
        onehot    = '0;
        onehot[i] = 1'b1;
        idx       = IW'(i);
      end
    end
  end

  assign any_free = |free;

endmodule

// File: rtl/bullet_pool_ctrl.sv
// bullet_pool_ctrl: per-player fire controller for a pool of NSLOTS bullets.
// Edge-detects the fire key, enforces a frame cooldown between shots,
// allocates the lowest free slot and issues a one-frame spawn pulse.
//   frame_clk       in   frame clock
//   Reset           in   async active-high reset
//   keycode         in   current keycode
//   direction       in   player facing
//   BallX/Y/S       in   player position and size
//   slot_done       in   per-slot "bullet ended"
//   spawn           out  one-hot one-frame launch pulse
//   spawn_dir/x/y   out  shot parameters, held until the next shot
//   slot_busy       out  occupancy bitmap
//   shots_fired     out  spawn count (wraps at 256)
//   state_cooldown  out  high in COOLDOWN
//
// state    | meaning
// ---------+-----------------------------------------------------
// READY    | a new press edge fires if any slot is free
// COOLDOWN | counting down COOLDOWN_FRAMES; presses are ignored
module bullet_pool_ctrl
  import bullet_pkg::*;
#(
  parameter int unsigned NSLOTS          = 4,
  parameter logic [7:0]  FIRE_KEY        = P2_FIRE_KEY,
  parameter int unsigned COOLDOWN_FRAMES = 6
) (
  input  logic              frame_clk,
  input  logic              Reset,
  input  logic [7:0]        keycode,
  input  dir_t              direction,
  input  logic [9:0]        BallX,
  input  logic [9:0]        BallY,
  input  logic [9:0]        BallS,
  input  logic [NSLOTS-1:0] slot_done,
  output logic [NSLOTS-1:0] spawn,
  output dir_t              spawn_dir,
  output logic [9:0]        spawn_x,
  output logic [9:0]        spawn_y,
  output logic [NSLOTS-1:0] slot_busy,
  output logic [7:0]        shots_fired,
  output logic              state_cooldown
);

  localparam int unsigned IW = (NSLOTS > 1) ? $clog2(NSLOTS) : 1;
  localparam int unsigned CW = (COOLDOWN_FRAMES > 1) ? $clog2(COOLDOWN_FRAMES) : 1;

  fire_state_t       state;
  logic [CW-1:0]     cnt;
  logic              fire_prev;
  logic              fire_req;
  logic              press;
  logic [NSLOTS-1:0] free;
  logic [NSLOTS-1:0] alloc_onehot;
  logic [IW-1:0]     alloc_idx;
  logic              any_free;
  logic [NSLOTS-1:0] busy_kept;

  assign fire_req  = (keycode == FIRE_KEY);
  assign press     = fire_req & ~fire_prev;
  // Allocation only sees pre-edge occupancy, so a slot released this frame
  // becomes allocatable one frame later and never collides with a release.
  assign free      = ~slot_busy;
  assign busy_kept = slot_busy & ~slot_done;

  bullet_slot_alloc #(
    .N  (NSLOTS),
    .IW (IW)
  ) u_alloc (
    .free     (free),
    .onehot   (alloc_onehot),
    .idx      (alloc_idx),
    .any_free (any_free)
  );

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state       <= READY;
      cnt         <= '0;
      fire_prev   <= 1'b1;   // a key held through reset must be re-pressed
      spawn       <= '0;
      slot_busy   <= '0;
      spawn_dir   <= DIR_LEFT;
      spawn_x     <= '0;
      spawn_y     <= '0;
      shots_fired <= '0;
    end else begin
      fire_prev <= fire_req;
      spawn     <= '0;
      slot_busy <= busy_kept;
      case (state)
        READY: begin
          if (press && any_free) begin
            spawn       <= alloc_onehot;
            slot_busy   <= busy_kept | (NSLOTS'(1) << alloc_idx);
            spawn_dir   <= direction;
            spawn_x     <= BallX + BallS;
            spawn_y     <= BallY + BallS;
            shots_fired <= shots_fired + 8'd1;
            cnt         <= CW'(COOLDOWN_FRAMES - 1);
            state       <= COOLDOWN;
          end
        end
        COOLDOWN: begin
          if (cnt == '0) state <= READY;
          else           cnt   <= cnt - 1'b1;
        end
        default: state <= READY;
      endcase
    end
  end

  assign state_cooldown = (state == COOLDOWN);

endmodule

// File: tb/tb_bullet_pool_ctrl.sv
// tb_bullet_pool_ctrl: directed scenarios plus randomized traffic, each frame
// checked against a frame-indexed reference model of the fire rules.
module tb_bullet_pool_ctrl;

  localparam int NS = 4;
  localparam int CD = 6;
  localparam logic [7:0] FK = 8'd88;

  logic          frame_clk = 1'b0;
  logic          Reset     = 1'b1;
  logic [7:0]    keycode   = FK;
  logic [1:0]    direction = 2'b00;
  logic [9:0]    BallX = 10'd0, BallY = 10'd0, BallS = 10'd0;
  logic [NS-1:0] slot_done = '0;
  logic [NS-1:0] spawn;
  logic [1:0]    spawn_dir;
  logic [9:0]    spawn_x, spawn_y;
  logic [NS-1:0] slot_busy;
  logic [7:0]    shots_fired;
  logic          state_cooldown;

  int checks   = 0;
  int failures = 0;

  // reference model state
  logic          m_prev;
  logic [NS-1:0] m_busy, m_spawn;
  int            m_shots, m_x, m_y, m_dir;
  int            edge_n, last_shot;

  bullet_pool_ctrl #(.NSLOTS(NS), .FIRE_KEY(FK), .COOLDOWN_FRAMES(CD)) dut (
    .frame_clk      (frame_clk),
    .Reset          (Reset),
    .keycode        (keycode),
    .direction      (direction),
    .BallX          (BallX),
    .BallY          (BallY),
    .BallS          (BallS),
    .slot_done      (slot_done),
    .spawn          (spawn),
    .spawn_dir      (spawn_dir),
    .spawn_x        (spawn_x),
    .spawn_y        (spawn_y),
    .slot_busy      (slot_busy),
    .shots_fired    (shots_fired),
    .state_cooldown (state_cooldown)
  );

  always #5 frame_clk = ~frame_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_prev    = 1'b1;
    m_busy    = '0;
    m_spawn   = '0;
    m_shots   = 0;
    m_x       = 0;
    m_y       = 0;
    m_dir     = 0;
    edge_n    = 0;
    last_shot = -1000;
  endtask

  // One frame of the rules: press edge, cooldown measured in frames since
  // the last shot, lowest free slot, release applied to pre-edge occupancy.
  task automatic model_edge();
    logic          req, press;
    int            slot;
    logic [NS-1:0] nb;
    req    = (keycode == FK);
    press  = req && !m_prev;
    m_prev = req;
    edge_n++;
    slot    = -1;
    m_spawn = '0;
    if (press && (edge_n - last_shot) > CD) begin
      for (int i = NS - 1; i >= 0; i--)
        if (!m_busy[i]) slot = i;
    end
    nb = m_busy & ~slot_done;
    if (slot >= 0) begin
      m_spawn[slot] = 1'b1;
      nb[slot]      = 1'b1;
      m_shots       = (m_shots + 1) % 256;
      m_x           = (int'(BallX) + int'(BallS)) % 1024;
      m_y           = (int'(BallY) + int'(BallS)) % 1024;
      m_dir         = int'(direction);
      last_shot     = edge_n;
    end
    m_busy = nb;
  endtask

  task automatic check_all();
    chk("spawn",          32'(spawn),          32'(m_spawn));
    chk("slot_busy",      32'(slot_busy),      32'(m_busy));
    chk("shots_fired",    32'(shots_fired),    32'(m_shots));
    chk("spawn_x",        32'(spawn_x),        32'(m_x));
    chk("spawn_y",        32'(spawn_y),        32'(m_y));
    chk("spawn_dir",      32'(spawn_dir),      32'(m_dir));
    chk("state_cooldown", 32'(state_cooldown), 32'((edge_n - last_shot) < CD));
  endtask

  task automatic step(input logic [7:0] kc, input logic [NS-1:0] done);
    @(negedge frame_clk);
    keycode   = kc;
    slot_done = done;
    @(posedge frame_clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic apply_reset(input logic [7:0] kc);
    Reset     = 1'b1;
    keycode   = kc;
    slot_done = '0;
    model_reset();
    #1;
    check_all();
    repeat (2) @(posedge frame_clk);
    @(negedge frame_clk);
    Reset = 1'b0;
    @(posedge frame_clk);
    model_edge();
    #1;
    check_all();
  endtask

  initial begin
    BallX = 10'd100; BallY = 10'd200; BallS = 10'd4; direction = 2'b11;

    // key held through reset must not fire until re-pressed
    apply_reset(FK);
    chk("rst_spawn", 32'(spawn), 32'd0);
    repeat (10) step(FK, '0);
    chk("held_no_shot", 32'(shots_fired), 32'd0);
    step(8'd0, '0);
    step(FK, '0);
    chk("first_spawn", 32'(spawn), 32'b0001);
    chk("first_count", 32'(shots_fired), 32'd1);
    chk("first_x", 32'(spawn_x), 32'd104);
    chk("first_y", 32'(spawn_y), 32'd204);
    chk("first_dir", 32'(spawn_dir), 32'd3);
    step(FK, '0);
    chk("pulse_end", 32'(spawn), 32'd0);
    chk("x_held", 32'(spawn_x), 32'd104);

    // press 3 frames after the shot is ignored; frame 7 fires
    step(8'd0, '0);
    step(FK, '0);
    chk("cooldown_ignore", 32'(spawn), 32'd0);
    repeat (3) step(8'd0, '0);
    step(FK, '0);
    chk("second_spawn", 32'(spawn), 32'b0010);

    // fill the pool, then overflow
    repeat (2) begin
      repeat (6) step(8'd0, '0);
      step(FK, '0);
    end
    chk("pool_full", 32'(slot_busy), 32'b1111);
    repeat (6) step(8'd0, '0);
    step(FK, '0);
    chk("full_no_spawn", 32'(spawn), 32'd0);
    chk("full_count", 32'(shots_fired), 32'd4);
    step(8'd0, 4'b0100);
    chk("release2", 32'(slot_busy), 32'b1011);
    step(FK, '0);
    chk("realloc2", 32'(spawn), 32'b0100);

    // release and press in the same frame: allocation sees pre-edge busy
    repeat (6) step(8'd0, '0);
    step(FK, 4'b0001);
    chk("same_frame_no_spawn", 32'(spawn), 32'd0);
    chk("same_frame_busy", 32'(slot_busy), 32'b1110);
    step(8'd0, '0);
    step(FK, '0);
    chk("realloc0", 32'(spawn), 32'b0001);

    // origin wraps mod 1024, then reset in the middle of COOLDOWN
    BallX = 10'd1020; BallY = 10'd0; BallS = 10'd8; direction = 2'b01;
    repeat (6) step(8'd0, 4'b0010);
    step(FK, '0);
    chk("wrap_x", 32'(spawn_x), 32'd4);
    chk("wrap_spawn", 32'(spawn), 32'b0010);
    step(8'd0, '0);
    chk("in_cooldown", 32'(state_cooldown), 32'd1);
    apply_reset(8'd0);

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      logic [7:0]    kc;
      logic [NS-1:0] dn;
      kc = ($urandom_range(0, 2) == 0) ? FK : 8'($urandom);
      dn = NS'($urandom & $urandom & $urandom);
      BallX = 10'($urandom); BallY = 10'($urandom); BallS = 10'($urandom);
      direction = 2'($urandom);
      if (n == 300) apply_reset(kc);
      else          step(kc, dn);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
